// File: rtl/oerv_immdec_p.sv
// rtl/oerv_immdec_p.sv - RISC-V immediate decoder delivering the immediate LSB-first in W-bit beats
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst        synchronous active-high reset
//   i_wb_en      fetch acknowledge, loads a new instruction
//   i_wb_rdt     fetched instruction bits [31:7]
//   i_imm_type   0=I 1=S 2=B 3=U 4=J 5=CSR uimm, 6/7 reserved (zero)
//   i_cnt_en     advance to the next immediate beat
//   o_imm        current W-bit beat of the immediate
//   o_rd_addr    rd field
//   o_rs1_addr   rs1 field
//   o_rs2_addr   rs2 field
//   o_valid      immediate loaded and not yet fully delivered
//   o_last       current beat is the final one
module oerv_immdec_p #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wb_en,
  input  logic [31:7]  i_wb_rdt,
  input  logic [2:0]   i_imm_type,
  input  logic         i_cnt_en,
  output logic [W-1:0] o_imm,
  output logic [4:0]   o_rd_addr,
  output logic [4:0]   o_rs1_addr,
  output logic [4:0]   o_rs2_addr,
  output logic         o_valid,
  output logic         o_last
);

  localparam int BEATS = 32 / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [2:0] T_I   = 3'd0;
  localparam logic [2:0] T_S   = 3'd1;
  localparam logic [2:0] T_B   = 3'd2;
  localparam logic [2:0] T_U   = 3'd3;
  localparam logic [2:0] T_J   = 3'd4;
  localparam logic [2:0] T_CSR = 3'd5;

  generate
    if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32)) begin : g_bad_w
      $error("oerv_immdec_p: W must be 1, 2, 4, 8, 16 or 32");
    end
  endgenerate

  logic [31:0]   imm_q, imm_d;
  logic          f_q, f_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [4:0]    rd_q, rd_d;
  logic [4:0]    rs1_q, rs1_d;
  logic [4:0]    rs2_q, rs2_d;

  logic [31:0]   load_imm;
  logic          load_f;
  logic [31:0]   shifted_imm;
  logic          last;

  assign last = valid_q && (cnt_q == CW'(BEATS - 1));

  // With W=32 there is nothing left to shift in from IMM; the word becomes all fill.
  generate
    if (W == 32) begin : g_shift_full
      assign shifted_imm = {32{f_q}};
    end else begin : g_shift_part
      assign shifted_imm = {{W{f_q}}, imm_q[31:W]};
    end
  endgenerate

  always_comb begin
    load_imm = 32'd0;
    load_f   = 1'b0;
    case (i_imm_type)
      T_I: begin
        load_imm = {{20{i_wb_rdt[31]}}, i_wb_rdt[31:20]};
        load_f   = i_wb_rdt[31];
      end
      T_S: begin
        load_imm = {{20{i_wb_rdt[31]}}, i_wb_rdt[31:25], i_wb_rdt[11:7]};
        load_f   = i_wb_rdt[31];
      end
      T_B: begin
        load_imm = {{19{i_wb_rdt[31]}}, i_wb_rdt[31], i_wb_rdt[7],
                    i_wb_rdt[30:25], i_wb_rdt[11:8], 1'b0};
        load_f   = i_wb_rdt[31];
      end
      T_U: begin
        load_imm = {i_wb_rdt[31:12], 12'd0};
      end
      T_J: begin
        load_imm = {{11{i_wb_rdt[31]}}, i_wb_rdt[31], i_wb_rdt[19:12],
                    i_wb_rdt[20], i_wb_rdt[30:21], 1'b0};
        load_f   = i_wb_rdt[31];
      end
      T_CSR: begin
        load_imm = {27'd0, i_wb_rdt[19:15]};
      end
      default: begin
        load_imm = 32'd0;
      end
    endcase
  end

  always_comb begin
    imm_d   = imm_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (i_wb_en) begin
      // A load wins over a simultaneous beat advance.
      imm_d   = load_imm;
      f_d     = load_f;
      cnt_d   = '0;
      valid_d = 1'b1;
      rd_d    = i_wb_rdt[11:7];
      rs1_d   = i_wb_rdt[19:15];
      rs2_d   = i_wb_rdt[24:20];
    end else if (i_cnt_en && valid_q) begin
      imm_d = shifted_imm;
      if (last) begin
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      imm_q   <= 32'd0;
      f_q     <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rd_q    <= 5'd0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
    end else begin
      imm_q   <= imm_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign o_imm      = imm_q[W-1:0];
  assign o_rd_addr  = rd_q;
  assign o_rs1_addr = rs1_q;
  assign o_rs2_addr = rs2_q;
  assign o_valid    = valid_q;
  assign o_last     = last;

endmodule

// File: tb/tb_oerv_immdec_p.sv
// tb/tb_oerv_immdec_p.sv - directed-vector bench for oerv_immdec_p at W=8 and W=1
module tb_oerv_immdec_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [31:7] wb_rdt;
  logic [2:0]  imm_type;
  logic        cnt_en;

  logic [7:0]  imm8;
  logic [4:0]  rd8, rs18, rs28;
  logic        valid8, last8;

  logic [0:0]  imm1;
  logic [4:0]  rd1, rs11, rs21;
  logic        valid1, last1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  oerv_immdec_p #(.W(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_wb_en(wb_en), .i_wb_rdt(wb_rdt),
    .i_imm_type(imm_type), .i_cnt_en(cnt_en), .o_imm(imm8),
    .o_rd_addr(rd8), .o_rs1_addr(rs18), .o_rs2_addr(rs28),
    .o_valid(valid8), .o_last(last8)
  );

  oerv_immdec_p #(.W(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_wb_en(wb_en), .i_wb_rdt(wb_rdt),
    .i_imm_type(imm_type), .i_cnt_en(cnt_en), .o_imm(imm1),
    .o_rd_addr(rd1), .o_rs1_addr(rs11), .o_rs2_addr(rs21),
    .o_valid(valid1), .o_last(last1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] t, input logic [31:0] inst);
    wb_en    = 1'b1;
    imm_type = t;
    wb_rdt   = inst[31:7];
    step();
    wb_en    = 1'b0;
  endtask

  task automatic beat();
    cnt_en = 1'b1;
    step();
    cnt_en = 1'b0;
  endtask

  // Walks the four W=8 beats, checking each byte and o_last, then expects o_valid low.
  task automatic deliver8(input string tag, input logic [31:0] exp_word);
    for (int b = 0; b < 4; b++) begin
      check({tag, " imm"}, {24'd0, imm8}, {24'd0, exp_word[8*b +: 8]});
      check({tag, " last"}, {31'd0, last8}, {31'd0, (b == 3)});
      beat();
    end
    check({tag, " valid_end"}, {31'd0, valid8}, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    wb_en    = 1'b0;
    wb_rdt   = '0;
    imm_type = 3'd0;
    cnt_en   = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst imm", {24'd0, imm8}, 32'd0);
    check("rst valid", {31'd0, valid8}, 32'd0);
    check("rst last", {31'd0, last8}, 32'd0);
    check("rst addrs", {17'd0, rd8, rs18, rs28}, 32'd0);

    // addi x1,x2,-1
    load(3'd0, 32'hFFF10093);
    check("I valid", {31'd0, valid8}, 32'd1);
    check("I rd", {27'd0, rd8}, 32'd1);
    check("I rs1", {27'd0, rs18}, 32'd2);
    check("I rs2", {27'd0, rs28}, 32'd31);
    deliver8("I", 32'hFFFFFFFF);
    check("I fill", {24'd0, imm8}, 32'hFF);
    check("I rd hold", {27'd0, rd8}, 32'd1);

    load(3'd3, 32'h123450B7);
    deliver8("U", 32'h12345000);

    // beq -4, then a beat while idle must not move anything
    load(3'd2, 32'hFE000EE3);
    deliver8("B", 32'hFFFFFFFC);
    beat();
    check("B idle imm", {24'd0, imm8}, 32'hFF);
    check("B idle valid", {31'd0, valid8}, 32'd0);
    check("B idle last", {31'd0, last8}, 32'd0);

    // CSR uimm = 0x1F
    load(3'd5, 32'h000F8073);
    deliver8("CSR", 32'h0000001F);

    load(3'd1, 32'hFE000FA3);
    deliver8("S", 32'hFFFFFFFF);

    load(3'd6, 32'hFFFFFFFF);
    check("rsv imm", {24'd0, imm8}, 32'd0);
    check("rsv valid", {31'd0, valid8}, 32'd1);

    // jal +8, serial delivery at W=1
    load(3'd4, 32'h0080006F);
    for (int b = 0; b < 32; b++) begin
      check($sformatf("J imm b%0d", b), {31'd0, imm1}, {31'd0, (b == 3)});
      check($sformatf("J last b%0d", b), {31'd0, last1}, {31'd0, (b == 31)});
      beat();
    end
    check("J valid_end", {31'd0, valid1}, 32'd0);

    // load and advance together mid-delivery: load wins, count restarts
    load(3'd0, 32'hFFF10093);
    beat();
    beat();
    cnt_en = 1'b1;
    load(3'd3, 32'h123450B7);
    cnt_en = 1'b0;
    check("coll rd", {27'd0, rd8}, 32'd1);
    deliver8("coll", 32'h12345000);

    // reset mid-delivery abandons the immediate
    load(3'd0, 32'hFFF10093);
    beat();
    beat();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst valid", {31'd0, valid8}, 32'd0);
    check("mrst imm", {24'd0, imm8}, 32'd0);
    check("mrst last", {31'd0, last8}, 32'd0);
    check("mrst addrs", {17'd0, rd8, rs18, rs28}, 32'd0);
    beat();
    check("mrst beat imm", {24'd0, imm8}, 32'd0);

    // reset beats a simultaneous load
    rst   = 1'b1;
    load(3'd0, 32'hFFF10093);
    rst   = 1'b0;
    check("rst>wb valid", {31'd0, valid8}, 32'd0);
    check("rst>wb rd", {27'd0, rd8}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
